// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and pipe_ctrl: stall requests,
// branch resolution, the stall/flush/redirect controls and the perf counters.
interface pipe_ctrl_if;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_mem;
    logic        ex_mispredict;
    logic [31:0] ex_target;
    logic [5:0]  stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    modport master (
        output stallreq_if, stallreq_id, stallreq_mem, ex_mispredict, ex_target,
        input  stall, flush, redirect_valid, redirect_pc, stall_cycles, flush_count
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_mem, ex_mispredict, ex_target,
        output stall, flush, redirect_valid, redirect_pc, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/redirect controller; a mispredict blocked by a busy data
// memory is parked until the memory frees. Optional counters: PIPE_CTRL_PERF_EN.
module pipe_ctrl (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] pend_target_r;
    logic [31:0] next_target_s;
    logic [5:0]  req_stall_s;
    logic [5:0]  stall_s;
    logic        flush_s;
    logic        redirect_valid_s;
    logic [31:0] redirect_pc_s;

    // Saturating increment shared by both performance counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        if (value == 32'hFFFF_FFFF) begin
            return value;
        end else begin
            return value + 32'd1;
        end
    endfunction

    // Stall vector implied by the raw requests alone, memory having top priority.
    always_comb begin
        req_stall_s = 6'b000000;
        if (bus.stallreq_mem) begin
            req_stall_s = 6'b011111;
        end else if (bus.stallreq_id) begin
            req_stall_s = 6'b000111;
        end else if (bus.stallreq_if) begin
            req_stall_s = 6'b000011;
        end else begin
            req_stall_s = 6'b000000;
        end
    end

    // Redirect decisions; a redirect overrides any decode/fetch stall so the PC can load.
    always_comb begin
        next_state_s     = state_r;
        next_target_s    = pend_target_r;
        stall_s          = 6'b000000;
        flush_s          = 1'b0;
        redirect_valid_s = 1'b0;
        redirect_pc_s    = 32'h0000_0000;
        if (rst) begin
            next_state_s  = IDLE;
            next_target_s = 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.ex_mispredict && !bus.stallreq_mem) begin
                        flush_s          = 1'b1;
                        redirect_valid_s = 1'b1;
                        redirect_pc_s    = bus.ex_target;
                    end else if (bus.ex_mispredict) begin
                        stall_s       = req_stall_s;
                        next_state_s  = PEND;
                        next_target_s = bus.ex_target;
                    end else begin
                        stall_s = req_stall_s;
                    end
                end
                PEND: begin
                    // Younger mispredicts are on the wrong path; the parked target wins.
                    if (bus.stallreq_mem) begin
                        stall_s = req_stall_s;
                    end else begin
                        flush_s          = 1'b1;
                        redirect_valid_s = 1'b1;
                        redirect_pc_s    = pend_target_r;
                        next_state_s     = IDLE;
                    end
                end
                default: begin
                    next_state_s  = IDLE;
                    next_target_s = 32'h0000_0000;
                end
            endcase
        end
    end

    // FSM state and parked redirect target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            pend_target_r <= 32'h0000_0000;
        end else begin
            state_r       <= next_state_s;
            pend_target_r <= next_target_s;
        end
    end

    assign bus.stall          = stall_s;
    assign bus.flush          = flush_s;
    assign bus.redirect_valid = redirect_valid_s;
    assign bus.redirect_pc    = redirect_pc_s;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_r;
    logic [31:0] flush_count_r;

    // Counts cycles with the PC frozen and cycles carrying a flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_r <= 32'h0000_0000;
            flush_count_r  <= 32'h0000_0000;
        end else begin
            if (stall_s[0]) begin
                stall_cycles_r <= sat_inc(stall_cycles_r);
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
            if (flush_s) begin
                flush_count_r <= sat_inc(flush_count_r);
            end else begin
                flush_count_r <= flush_count_r;
            end
        end
    end

    assign bus.stall_cycles = stall_cycles_r;
    assign bus.flush_count  = flush_count_r;
`else
    assign bus.stall_cycles = 32'h0000_0000;
    assign bus.flush_count  = 32'h0000_0000;
`endif

endmodule
